// File: rtl/avmm_to_axis_reader.sv
// rtl/avmm_to_axis_reader.sv - Avalon-MM burst-less reader feeding an AXI-Stream master
//
// Purpose: on an accepted start command, fetch `length` consecutive words
// starting at `base_addr` using pipelined Avalon-MM reads. The words are
// buffered in a DEPTH-entry FIFO and emitted in address order on m_t*.
//
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   start, base_addr, length    command strobe and its operands (IDLE only)
//   busy, done                  transfer in progress / one-cycle completion pulse
//   avm_*                       Avalon-MM read master
//   m_tdata/m_tvalid/m_tready/m_tlast   AXI-Stream master
module avmm_to_axis_reader #(
  parameter int W_DATA = 37,
  parameter int W_ADDR = 16,
  parameter int W_LEN  = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [W_ADDR-1:0] base_addr,
  input  logic [W_LEN-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [W_ADDR-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [W_DATA-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [W_DATA-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast
);

  localparam int W_PTR = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int W_CNT = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic [W_DATA-1:0] fifo_mem [DEPTH];
  logic [W_PTR-1:0]  wr_ptr;
  logic [W_PTR-1:0]  rd_ptr;
  logic [W_CNT-1:0]  fifo_count;
  logic [W_CNT-1:0]  outstanding;
  logic [W_LEN-1:0]  len_q;
  logic [W_LEN-1:0]  issue_cnt;
  logic [W_LEN-1:0]  recv_cnt;
  logic [W_LEN-1:0]  send_cnt;

  logic              active;
  logic              accept;
  logic              final_accept;
  logic              push;
  logic              pop;
  logic              last_hs;
  logic              credit_ok;
  logic [W_LEN-1:0]  len_m1;
  logic [W_CNT-1:0]  fifo_count_nxt;
  logic [W_CNT-1:0]  outstanding_nxt;
  logic [W_LEN-1:0]  send_cnt_nxt;
  logic [W_CNT:0]    credit_sum;

  always_comb begin
    active       = (state == S_READ) || (state == S_DRAIN);
    accept       = (state == S_READ) && avm_read && !avm_waitrequest;
    len_m1       = len_q - W_LEN'(1);
    final_accept = accept && (issue_cnt == len_m1);
    // Responses outside a transfer, or beyond the requested count, are dropped.
    push         = active && avm_readdatavalid && (recv_cnt != len_q);
    pop          = active && m_tvalid && m_tready;
    last_hs      = pop && m_tlast;

    fifo_count_nxt  = fifo_count + W_CNT'(push) - W_CNT'(pop);
    outstanding_nxt = outstanding + W_CNT'(accept) - W_CNT'(push);
    send_cnt_nxt    = send_cnt + W_LEN'(pop);

    // Credit is judged on post-edge occupancy: every word in flight already
    // owns a FIFO slot, so the FIFO cannot overflow.
    credit_sum = {1'b0, fifo_count_nxt} + {1'b0, outstanding_nxt};
    credit_ok  = credit_sum < (W_CNT + 1)'(DEPTH);
  end

  // The head entry is a register, so the stream data is registered and holds
  // still while stalled (rd_ptr only moves on a handshake).
  assign m_tdata = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= avm_readdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      avm_read    <= 1'b0;
      avm_address <= '0;
      m_tvalid    <= 1'b0;
      m_tlast     <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      outstanding <= '0;
      len_q       <= '0;
      issue_cnt   <= '0;
      recv_cnt    <= '0;
      send_cnt    <= '0;
    end else begin
      done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            len_q       <= length;
            issue_cnt   <= '0;
            recv_cnt    <= '0;
            send_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
            busy        <= 1'b1;
            if (length != '0) begin
              state       <= S_READ;
              avm_read    <= 1'b1;
              avm_address <= base_addr;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end

        S_READ: begin
          if (accept) begin
            avm_address <= avm_address + W_ADDR'(1);
            issue_cnt   <= issue_cnt + W_LEN'(1);
          end
          if (final_accept) begin
            avm_read <= 1'b0;
            state    <= S_DRAIN;
          end else if (!(avm_read && avm_waitrequest)) begin
            // Not holding a stalled request: (re)raise only with credit.
            avm_read <= credit_ok;
          end
        end

        S_DRAIN: begin
          if (last_hs) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase

      if (active) begin
        if (push) begin
          wr_ptr   <= wr_ptr + W_PTR'(1);
          recv_cnt <= recv_cnt + W_LEN'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + W_PTR'(1);
        end
        fifo_count  <= fifo_count_nxt;
        outstanding <= outstanding_nxt;
        send_cnt    <= send_cnt_nxt;
        m_tvalid    <= (fifo_count_nxt != '0);
        m_tlast     <= (fifo_count_nxt != '0) && (send_cnt_nxt == len_m1);
      end
    end
  end

endmodule
